// File: rtl/eight_bit_1_2_demux_buf.sv
// 1:2 byte demultiplexer with a one-entry valid/ready buffer per output channel
// and per-channel accept counters. Define AUTO_ALT_EN to alternate channels on each accept instead of using s.
module eight_bit_1_2_demux_buf (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       s,
   output logic [7:0] out_a,
   output logic       a_valid,
   input  logic       a_ready,
   output logic [7:0] out_b,
   output logic       b_valid,
   input  logic       b_ready,
   output logic [7:0] cnt_a,
   output logic [7:0] cnt_b
);

   logic       tgt;
   logic       accept;
   logic       load_a;
   logic       load_b;

   logic [7:0] out_a_q, out_a_d;
   logic [7:0] out_b_q, out_b_d;
   logic       a_valid_q, a_valid_d;
   logic       b_valid_q, b_valid_d;
   logic [7:0] cnt_a_q, cnt_a_d;
   logic [7:0] cnt_b_q, cnt_b_d;

`ifdef AUTO_ALT_EN
   logic alt_q, alt_d;
   logic unused_s;

   // Route select is ignored in alternating mode.
   assign unused_s = s;
   assign tgt      = alt_q;

   always_comb begin
      alt_d = alt_q;
      if (accept) alt_d = ~alt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) alt_q <= 1'b0;
      else     alt_q <= alt_d;
   end
`else
   assign tgt = s;
`endif

   // Only the targeted buffer gates acceptance; the other channel drains freely.
   always_comb begin
      in_ready = 1'b0;
      if (tgt) in_ready = !b_valid_q || b_ready;
      else     in_ready = !a_valid_q || a_ready;
   end

   assign accept = in_valid && in_ready;
   assign load_a = accept && !tgt;
   assign load_b = accept && tgt;

   always_comb begin
      out_a_d   = out_a_q;
      out_b_d   = out_b_q;
      a_valid_d = a_valid_q;
      b_valid_d = b_valid_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;

      if (a_valid_q && a_ready) a_valid_d = 1'b0;
      if (b_valid_q && b_ready) b_valid_d = 1'b0;

      // A load wins over a same-cycle drain so the channel streams without a bubble.
      if (load_a) begin
         out_a_d   = in_data;
         a_valid_d = 1'b1;
         cnt_a_d   = cnt_a_q + 8'd1;
      end
      if (load_b) begin
         out_b_d   = in_data;
         b_valid_d = 1'b1;
         cnt_b_d   = cnt_b_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_a_q   <= 8'h00;
         out_b_q   <= 8'h00;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         cnt_a_q   <= 8'h00;
         cnt_b_q   <= 8'h00;
      end else begin
         out_a_q   <= out_a_d;
         out_b_q   <= out_b_d;
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
      end
   end

   assign out_a   = out_a_q;
   assign out_b   = out_b_q;
   assign a_valid = a_valid_q;
   assign b_valid = b_valid_q;
   assign cnt_a   = cnt_a_q;
   assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_eight_bit_1_2_demux_buf.sv
// Self-checking bench for eight_bit_1_2_demux_buf: directed scenarios plus a
// randomized run against a channel-level reference model.
module tb_eight_bit_1_2_demux_buf;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       s;
   logic [7:0] out_a;
   logic       a_valid;
   logic       a_ready;
   logic [7:0] out_b;
   logic       b_valid;
   logic       b_ready;
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;

   int checks   = 0;
   int failures = 0;

   // Reference model: index 0 is channel a, index 1 is channel b.
   bit         m_full [2];
   logic [7:0] m_data [2];
   logic [7:0] m_cnt  [2];
   bit         m_tog;

   eight_bit_1_2_demux_buf dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .s(s), .out_a(out_a), .a_valid(a_valid),
      .a_ready(a_ready), .out_b(out_b), .b_valid(b_valid), .b_ready(b_ready),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_target();
`ifdef AUTO_ALT_EN
      return m_tog;
`else
      return s;
`endif
   endfunction

   function automatic bit m_ready_in();
      bit t;
      t = m_target();
      return !m_full[t] || (t ? b_ready : a_ready);
   endfunction

   // Advance one clock: compute the model's next state from the driven inputs,
   // then let the DUT take the edge and sample 1 time unit later.
   task automatic tick();
      bit         n_full [2];
      logic [7:0] n_data [2];
      logic [7:0] n_cnt  [2];
      bit         n_tog;
      bit         t;
      n_full = m_full; n_data = m_data; n_cnt = m_cnt; n_tog = m_tog;
      if (rst) begin
         n_full = '{0, 0}; n_data = '{8'h00, 8'h00}; n_cnt = '{8'h00, 8'h00}; n_tog = 0;
      end else begin
         if (m_full[0] && a_ready) n_full[0] = 0;
         if (m_full[1] && b_ready) n_full[1] = 0;
         if (in_valid && m_ready_in()) begin
            t = m_target();
            n_full[t] = 1;
            n_data[t] = in_data;
            n_cnt[t]  = m_cnt[t] + 8'd1;
            n_tog     = !m_tog;
         end
      end
      @(posedge clk);
      #1;
      m_full = n_full; m_data = n_data; m_cnt = n_cnt; m_tog = n_tog;
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 0; s = 0; a_ready = 0; b_ready = 0; in_data = 8'h00;
      tick();
      rst = 0;
      #1;
      checks++;
      if ({a_valid, b_valid, out_a, out_b, cnt_a, cnt_b} !== 34'h0) begin
         failures++;
         $display("FAIL reset_state: got av=%b bv=%b oa=%h ob=%h ca=%h cb=%h, want all zero",
                  a_valid, b_valid, out_a, out_b, cnt_a, cnt_b);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

`ifndef AUTO_ALT_EN
   task automatic test_single_accept();
      s = 0; in_data = 8'h5A; in_valid = 1; a_ready = 0; b_ready = 0;
      tick();
      in_valid = 0;
      checks++;
      if ({out_a, a_valid, cnt_a, b_valid} !== {8'h5A, 1'b1, 8'd1, 1'b0}) begin
         failures++;
         $display("FAIL single_accept: got oa=%h av=%b ca=%0d bv=%b, want 5a 1 1 0",
                  out_a, a_valid, cnt_a, b_valid);
      end
   endtask

   task automatic test_backpressure();
      s = 0; in_data = 8'h77; in_valid = 1; a_ready = 0; b_ready = 0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      tick();
      checks++;
      if ({out_a, cnt_a, b_valid} !== {8'h5A, 8'd1, 1'b0}) begin
         failures++;
         $display("FAIL stall_hold: got oa=%h ca=%0d bv=%b, want 5a 1 0", out_a, cnt_a, b_valid);
      end
      s = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL redirect_in_ready: got %b want 1", in_ready);
      end
      tick();
      in_valid = 0;
      checks++;
      if ({out_b, b_valid, cnt_b, out_a, a_valid} !== {8'h77, 1'b1, 8'd1, 8'h5A, 1'b1}) begin
         failures++;
         $display("FAIL redirect_to_b: got ob=%h bv=%b cb=%0d oa=%h av=%b, want 77 1 1 5a 1",
                  out_b, b_valid, cnt_b, out_a, a_valid);
      end
   endtask

   task automatic test_back_to_back();
      a_ready = 1; in_valid = 0;
      tick();
      a_ready = 0;
      checks++;
      if ({a_valid, out_a, cnt_a} !== {1'b0, 8'h5A, 8'd1}) begin
         failures++;
         $display("FAIL drain_hold: got av=%b oa=%h ca=%0d, want 0 5a 1", a_valid, out_a, cnt_a);
      end
      s = 0; in_data = 8'h11; in_valid = 1;
      tick();
      in_data = 8'h22; a_ready = 1; b_ready = 1;
      tick();
      in_valid = 0; a_ready = 0; b_ready = 0;
      checks++;
      if ({a_valid, out_a, cnt_a, b_valid, out_b} !== {1'b1, 8'h22, 8'd3, 1'b0, 8'h77}) begin
         failures++;
         $display("FAIL drain_and_load: got av=%b oa=%h ca=%0d bv=%b ob=%h, want 1 22 3 0 77",
                  a_valid, out_a, cnt_a, b_valid, out_b);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] start;
      int         stalls = 0;
      start = m_cnt[1];
      s = 1; b_ready = 1; in_valid = 1;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i);
         #1;
         if (in_ready !== 1'b1) stalls++;
         tick();
      end
      in_valid = 0; b_ready = 0;
      checks++;
      if (stalls != 0) begin
         failures++;
         $display("FAIL wrap_stream: got %0d stalled cycles want 0", stalls);
      end
      checks++;
      if ({cnt_b, b_valid, out_b} !== {start, 1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL wrap_count: got cb=%h bv=%b ob=%h, want %h 1 ff", cnt_b, b_valid, out_b, start);
      end
   endtask

   task automatic test_reset_mid();
      s = 0; in_data = 8'hA1; in_valid = 1; a_ready = 0; b_ready = 0;
      tick();
      rst = 1; s = 0; in_data = 8'hEE;
      tick();
      rst = 0; in_valid = 0;
      #1;
      checks++;
      if ({a_valid, b_valid, cnt_a, cnt_b, in_ready} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid: got av=%b bv=%b ca=%0d cb=%0d ir=%b, want 0 0 0 0 1",
                  a_valid, b_valid, cnt_a, cnt_b, in_ready);
      end
   endtask
`else
   task automatic test_auto_alt();
      logic [7:0] exp_a [4] = '{8'd1, 8'd1, 8'd3, 8'd3};
      logic [7:0] exp_b [4] = '{8'd0, 8'd2, 8'd2, 8'd4};
      s = 1; a_ready = 1; b_ready = 1; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'(i + 1);
         tick();
         checks++;
         if ({out_a, out_b} !== {exp_a[i], exp_b[i]}) begin
            failures++;
            $display("FAIL auto_alt_%0d: got oa=%h ob=%h, want %h %h", i, out_a, out_b, exp_a[i], exp_b[i]);
         end
      end
      in_valid = 0;
      checks++;
      if ({cnt_a, cnt_b} !== {8'd2, 8'd2}) begin
         failures++;
         $display("FAIL auto_alt_cnt: got ca=%0d cb=%0d want 2 2", cnt_a, cnt_b);
      end
   endtask
`endif

   task automatic test_random();
      int bad_ready = 0;
      int bad_state = 0;
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         s        = 1'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         a_ready  = 1'($urandom);
         b_ready  = ($urandom_range(0, 3) == 0);
         #1;
         if (!rst && in_ready !== m_ready_in()) begin
            bad_ready++;
            if (bad_ready <= 5)
               $display("FAIL rand_in_ready cycle %0d: got %b want %b", i, in_ready, m_ready_in());
         end
         tick();
         if ({a_valid, b_valid, out_a, out_b, cnt_a, cnt_b} !==
             {m_full[0], m_full[1], m_data[0], m_data[1], m_cnt[0], m_cnt[1]}) begin
            bad_state++;
            if (bad_state <= 5)
               $display("FAIL rand_state cycle %0d: got %b%b %h %h %h %h want %b%b %h %h %h %h", i,
                        a_valid, b_valid, out_a, out_b, cnt_a, cnt_b,
                        m_full[0], m_full[1], m_data[0], m_data[1], m_cnt[0], m_cnt[1]);
         end
      end
      rst = 0; in_valid = 0;
      checks++;
      if (bad_ready != 0) failures++;
      checks++;
      if (bad_state != 0) failures++;
   endtask

   initial begin
      rst = 0; s = 0; in_valid = 0; in_data = 8'h00; a_ready = 0; b_ready = 0;
      m_full = '{0, 0}; m_data = '{8'h00, 8'h00}; m_cnt = '{8'h00, 8'h00}; m_tog = 0;
      test_reset();
`ifndef AUTO_ALT_EN
      test_single_accept();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
`else
      test_auto_alt();
`endif
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eight_bit_1_2_demux_buf.md
EIGHT_BIT_1_2_DEMUX_BUF -- requirements
Module: eight_bit_1_2_demux_buf

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  8  byte offered by the upstream source.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept in_data this cycle (combinational).
REQ-007 s  input  1  route select: 0 -> channel a, 1 -> channel b.
REQ-008 out_a  output  8  channel a buffered byte.
REQ-009 a_valid  output  1  out_a holds an undelivered byte.
REQ-010 a_ready  input  1  channel a consumer takes out_a this cycle.
REQ-011 out_b  output  8  channel b buffered byte.
REQ-012 b_valid  output  1  out_b holds an undelivered byte.
REQ-013 b_ready  input  1  channel b consumer takes out_b this cycle.
REQ-014 cnt_a  output  8  bytes accepted for channel a, modulo 256.
REQ-015 cnt_b  output  8  bytes accepted for channel b, modulo 256.

Function
REQ-016 Target channel tgt SHALL be s, or the internal toggle bit when AUTO_ALT_EN is defined.
REQ-017 in_ready SHALL equal (tgt valid == 0) OR (tgt ready == 1); the non-target channel SHALL NOT affect in_ready.
REQ-018 Accept SHALL occur when in_valid && in_ready; on accept, target data register SHALL load in_data and target valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-019 Drain SHALL occur when x_valid && x_ready; without a simultaneous load, x_valid SHALL clear next cycle.
REQ-020 Simultaneous drain and load on one channel: x_valid SHALL stay 1 and out_x SHALL take the new byte; no bubble.
REQ-021 x_ready while x_valid == 0 SHALL have no effect.
REQ-022 out_x SHALL hold its last value when not loaded, including after drain.
REQ-023 Non-target channel SHALL drain independently in the same cycle as a load to the target.
REQ-024 in_valid with in_ready == 0 SHALL leave all state unchanged; in_data SHALL NOT be latched.
REQ-025 cnt_x SHALL increment by 1 per accept to channel x, wrapping 255 -> 0; no increment on drain.
REQ-026 Each channel SHALL be a one-entry buffer: valid empty/full states only; no byte SHALL be dropped or duplicated.

Reset
REQ-027 With rst == 1 at a rising edge: out_a, out_b, cnt_a, cnt_b = 8'h00; a_valid, b_valid = 0; toggle bit = 0.
REQ-028 Reset mid-operation SHALL discard buffered bytes; an accept coincident with rst SHALL NOT load or count.
REQ-029 in_ready SHALL be 1 on the first cycle after reset release (both buffers empty).

Configuration
REQ-030 Macro AUTO_ALT_EN defined: s SHALL be ignored; toggle bit starts at channel a and SHALL invert after each accept; no accept, no toggle.
REQ-031 AUTO_ALT_EN undefined: no toggle register SHALL exist; tgt = s every cycle.

Verification
REQ-032 Reset, s=0, in_data=8'h5A, in_valid=1 one cycle, a_ready=0 -> next cycle out_a=8'h5A, a_valid=1, cnt_a=1, b_valid=0.
REQ-033 a_valid=1, a_ready=0, s=0, in_valid=1 -> in_ready=0; out_a unchanged; cnt_a unchanged; then s=1 same cycle -> in_ready=1, byte lands in out_b.
REQ-034 a_valid=1 with 8'h11, a_ready=1, in_data=8'h22, s=0, in_valid=1 -> next cycle a_valid=1, out_a=8'h22, cnt_a incremented.
REQ-035 256 back-to-back accepts to channel b with b_ready=1 -> cnt_b returns to 8'h00, b_valid=1 holding last byte.
REQ-036 rst asserted while a_valid=b_valid=1 and an accept is offered -> next cycle all valids 0, counts 0, in_ready=1.
REQ-037 AUTO_ALT_EN build, s held 1, bytes 1,2,3,4 accepted with both readys=1 -> out_a sees 1,3; out_b sees 2,4; cnt_a=cnt_b=2.
